// File: rtl/debug_dump_sequencer.sv
// Streams PC, registers and data memory words over the 32-bit UART handshake.
// Define DEBUG_DUMP_CHECKSUM_EN to append an XOR checksum word to each dump.
module debug_dump_sequencer #(
    parameter int NB_DATA        = 32,
    parameter int NB_REG_ADDRESS = 5,
    parameter int NB_MEM_ADDRESS = 7,
    parameter int N_REGS         = 32,
    parameter int N_MEM_WORDS    = 128
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic                      i_abort,
    input  logic                      i_tx_done_32b_word,
    input  logic [NB_DATA-1:0]        i_read_pc,
    input  logic [NB_DATA-1:0]        i_debug_read_reg,
    input  logic [NB_DATA-1:0]        i_debug_read_mem,
    output logic [NB_REG_ADDRESS-1:0] o_debug_read_reg_address,
    output logic [NB_MEM_ADDRESS-1:0] o_debug_read_mem_address,
    output logic                      o_enable_uart_send_data,
    output logic [NB_DATA-1:0]        o_data_to_send,
    output logic                      o_busy,
    output logic                      o_done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SEND,
        ST_WAIT,
        ST_FINISH
    } state_t;

    typedef enum logic [1:0] {
        SEC_PC,
        SEC_REG,
        SEC_MEM,
        SEC_CSUM
    } section_t;

    localparam logic [NB_REG_ADDRESS-1:0] LAST_REG =
        NB_REG_ADDRESS'(N_REGS - 1);
    localparam logic [NB_MEM_ADDRESS-1:0] LAST_MEM =
        NB_MEM_ADDRESS'(N_MEM_WORDS - 1);

    state_t             state;
    section_t           section;
    logic [NB_DATA-1:0] load_word;
    logic               kill;

`ifdef DEBUG_DUMP_CHECKSUM_EN
    logic [NB_DATA-1:0] csum;
`endif

    // Reset and abort both drop everything back to a clean IDLE
    assign kill = !i_reset || (i_abort && state != ST_IDLE);

    // Select the word captured in LOAD from the active section
    always_comb begin
        load_word = '0;
        case (section)
            SEC_PC:   load_word = i_read_pc;
            SEC_REG:  load_word = i_debug_read_reg;
            SEC_MEM:  load_word = i_debug_read_mem;
`ifdef DEBUG_DUMP_CHECKSUM_EN
            SEC_CSUM: load_word = csum;
`endif
            default:  load_word = '0;
        endcase
    end

    // Dump sequencer: walks the sections one word per UART transaction
    always_ff @(posedge i_clock) begin
        if (kill) begin
            state                    <= ST_IDLE;
            section                  <= SEC_PC;
            o_debug_read_reg_address <= '0;
            o_debug_read_mem_address <= '0;
            o_enable_uart_send_data  <= 1'b0;
            o_data_to_send           <= '0;
            o_busy                   <= 1'b0;
            o_done                   <= 1'b0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
            csum                     <= '0;
`endif
        end else begin
            o_enable_uart_send_data <= 1'b0;
            o_done                  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state                    <= ST_FETCH;
                        section                  <= SEC_PC;
                        o_debug_read_reg_address <= '0;
                        o_debug_read_mem_address <= '0;
                        o_busy                   <= 1'b1;
`ifdef DEBUG_DUMP_CHECKSUM_EN
                        csum                     <= '0;
`endif
                    end
                end
                ST_FETCH: begin
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    o_data_to_send          <= load_word;
                    o_enable_uart_send_data <= 1'b1;
                    state                   <= ST_SEND;
`ifdef DEBUG_DUMP_CHECKSUM_EN
                    if (section != SEC_CSUM)
                        csum <= csum ^ load_word;
`endif
                end
                ST_SEND: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_tx_done_32b_word) begin
                        state <= ST_FETCH;
                        case (section)
                            SEC_PC: begin
                                section                  <= SEC_REG;
                                o_debug_read_reg_address <= '0;
                            end
                            SEC_REG: begin
                                if (o_debug_read_reg_address == LAST_REG) begin
                                    section                  <= SEC_MEM;
                                    o_debug_read_mem_address <= '0;
                                end else begin
                                    o_debug_read_reg_address <=
                                        o_debug_read_reg_address
                                        + NB_REG_ADDRESS'(1);
                                end
                            end
                            SEC_MEM: begin
                                if (o_debug_read_mem_address == LAST_MEM) begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
                                    section <= SEC_CSUM;
`else
                                    state  <= ST_FINISH;
                                    o_done <= 1'b1;
`endif
                                end else begin
                                    o_debug_read_mem_address <=
                                        o_debug_read_mem_address
                                        + NB_MEM_ADDRESS'(1);
                                end
                            end
                            default: begin
                                state  <= ST_FINISH;
                                o_done <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_FINISH: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Testbench for debug_dump_sequencer: directed steps, random data, queue model.
// Honours DEBUG_DUMP_CHECKSUM_EN to expect the trailing checksum word.
module tb_debug_dump_sequencer;

    localparam int NB_DATA        = 32;
    localparam int NB_REG_ADDRESS = 5;
    localparam int NB_MEM_ADDRESS = 7;
    localparam int N_REGS         = 4;
    localparam int N_MEM_WORDS    = 2;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    localparam bit HAS_CSUM = 1'b1;
`else
    localparam bit HAS_CSUM = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      i_reset;
    logic                      i_start;
    logic                      i_abort;
    logic                      i_tx_done_32b_word;
    logic [NB_DATA-1:0]        i_read_pc;
    logic [NB_DATA-1:0]        i_debug_read_reg;
    logic [NB_DATA-1:0]        i_debug_read_mem;
    logic [NB_REG_ADDRESS-1:0] o_debug_read_reg_address;
    logic [NB_MEM_ADDRESS-1:0] o_debug_read_mem_address;
    logic                      o_enable_uart_send_data;
    logic [NB_DATA-1:0]        o_data_to_send;
    logic                      o_busy;
    logic                      o_done;

    debug_dump_sequencer #(
        .NB_DATA        (NB_DATA),
        .NB_REG_ADDRESS (NB_REG_ADDRESS),
        .NB_MEM_ADDRESS (NB_MEM_ADDRESS),
        .N_REGS         (N_REGS),
        .N_MEM_WORDS    (N_MEM_WORDS)
    ) dut (
        .i_clock                  (clk),
        .i_reset                  (i_reset),
        .i_start                  (i_start),
        .i_abort                  (i_abort),
        .i_tx_done_32b_word       (i_tx_done_32b_word),
        .i_read_pc                (i_read_pc),
        .i_debug_read_reg         (i_debug_read_reg),
        .i_debug_read_mem         (i_debug_read_mem),
        .o_debug_read_reg_address (o_debug_read_reg_address),
        .o_debug_read_mem_address (o_debug_read_mem_address),
        .o_enable_uart_send_data  (o_enable_uart_send_data),
        .o_data_to_send           (o_data_to_send),
        .o_busy                   (o_busy),
        .o_done                   (o_done)
    );

    always #5 clk = ~clk;

    // Synchronous-read register file and data memory
    logic [NB_DATA-1:0] regs [0:(1<<NB_REG_ADDRESS)-1];
    logic [NB_DATA-1:0] mems [0:(1<<NB_MEM_ADDRESS)-1];

    always @(posedge clk) begin
        i_debug_read_reg <= regs[o_debug_read_reg_address];
        i_debug_read_mem <= mems[o_debug_read_mem_address];
    end

    // UART model: done about 10 cycles after each send pulse,
    // optionally followed by 3 spurious done cycles
    int unsigned tx_cnt    = 0;
    int unsigned spur_cnt  = 0;
    logic        uart_done = 1'b0;
    bit          spur_en   = 1'b0;

    always @(posedge clk) begin
        if (o_enable_uart_send_data) tx_cnt <= 10;
        else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
        uart_done <= (tx_cnt == 1);
        if (spur_en && uart_done) spur_cnt <= 3;
        else if (spur_cnt != 0) spur_cnt <= spur_cnt - 1;
    end

    assign i_tx_done_32b_word = uart_done | (spur_cnt != 0);

    // Monitor: record every sent word, its cycle, and done pulses
    int                 cyc = 0;
    logic [NB_DATA-1:0] cap [$];
    int                 cap_t [$];
    int                 done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_enable_uart_send_data) begin
            cap.push_back(o_data_to_send);
            cap_t.push_back(cyc);
        end
        if (o_done) done_cnt++;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h",
                    tag, obs, exp);
    endtask

    // One full dump checked against the expected word list
    task automatic run_dump(input bit directed, input bit mid_start);
        logic [NB_DATA-1:0] exp [$];
        logic [NB_DATA-1:0] x;
        int base, d0, s, k;
        if (directed) begin
            i_read_pc = 32'h40;
            for (int i = 0; i < N_REGS; i++) regs[i] = 32'h100 + i;
            for (int j = 0; j < N_MEM_WORDS; j++) mems[j] = 32'hA000 + j;
        end else begin
            i_read_pc = $urandom;
            for (int i = 0; i < N_REGS; i++) regs[i] = $urandom;
            for (int j = 0; j < N_MEM_WORDS; j++) mems[j] = $urandom;
        end
        exp.push_back(i_read_pc);
        for (int i = 0; i < N_REGS; i++) exp.push_back(regs[i]);
        for (int j = 0; j < N_MEM_WORDS; j++) exp.push_back(mems[j]);
        x = '0;
        foreach (exp[i]) x = x ^ exp[i];
        if (HAS_CSUM) exp.push_back(x);

        base = cap.size();
        d0   = done_cnt;
        @(negedge clk); #1;
        check("idle_busy", o_busy, 0);
        i_start = 1'b1;
        s = cyc;
        @(negedge clk); #1;
        i_start = 1'b0;
        check("busy_after_start", o_busy, 1);
        k = 0;
        while (done_cnt == d0 && k < 1000) begin
            @(negedge clk); #1;
            i_start = mid_start && (k == 40);
            k++;
        end
        i_start = 1'b0;
        check("done_once", done_cnt - d0, 1);
        check("done_level", o_done, 1);
        check("busy_in_finish", o_busy, 1);
        check("word_count", cap.size() - base, exp.size());
        foreach (exp[i])
            if (base + i < cap.size())
                check($sformatf("word%0d", i), cap[base+i], exp[i]);
        if (cap.size() > base)
            check("first_latency", cap_t[base] - s, 3);
    endtask

    initial begin
        int base, d0, k;
        i_reset   = 1'b0;
        i_start   = 1'b0;
        i_abort   = 1'b0;
        i_read_pc = '0;
        for (int i = 0; i < (1<<NB_REG_ADDRESS); i++) regs[i] = '0;
        for (int j = 0; j < (1<<NB_MEM_ADDRESS); j++) mems[j] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("reset_outs",
              {o_enable_uart_send_data, o_done, o_busy, o_data_to_send,
               o_debug_read_reg_address, o_debug_read_mem_address}, 0);
        i_reset = 1'b1;

        // Basic dump with the reference data
        run_dump(1'b1, 1'b0);

        // Spurious done in FETCH/LOAD/SEND plus a start mid-dump
        spur_en = 1'b1;
        run_dump(1'b0, 1'b1);
        spur_en = 1'b0;
        repeat (5) @(negedge clk);

        // Abort during WAIT of reg 2, coincident with done
        base = cap.size();
        d0   = done_cnt;
        @(negedge clk); #1;
        i_start = 1'b1;
        @(negedge clk); #1;
        i_start = 1'b0;
        k = 0;
        while (cap.size() < base + 4 && k < 500) begin
            @(negedge clk); #1;
            k++;
        end
        k = 0;
        while (uart_done !== 1'b1 && k < 100) begin
            @(negedge clk); #1;
            k++;
        end
        check("abort_at_done", uart_done, 1);
        i_abort = 1'b1;
        @(negedge clk); #1;
        i_abort = 1'b0;
        check("abort_busy", o_busy, 0);
        check("abort_outs",
              {o_enable_uart_send_data, o_done, o_data_to_send,
               o_debug_read_reg_address, o_debug_read_mem_address}, 0);
        repeat (30) @(negedge clk);
        #1;
        check("abort_no_pulse", cap.size() - base, 4);
        check("abort_no_done", done_cnt - d0, 0);

        // Fresh dump after abort restarts from PC
        run_dump(1'b0, 1'b0);
        repeat (5) @(negedge clk);

        // Reset pulse during mem word 0
        base = cap.size();
        d0   = done_cnt;
        @(negedge clk); #1;
        i_start = 1'b1;
        @(negedge clk); #1;
        i_start = 1'b0;
        k = 0;
        while (cap.size() < base + 6 && k < 500) begin
            @(negedge clk); #1;
            k++;
        end
        check("reset_reached", cap.size() - base, 6);
        @(negedge clk); #1;
        i_reset = 1'b0;
        @(negedge clk); #1;
        check("midreset_outs",
              {o_enable_uart_send_data, o_done, o_busy, o_data_to_send,
               o_debug_read_reg_address, o_debug_read_mem_address}, 0);
        i_reset = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("reset_no_pulse", cap.size() - base, 6);
        check("reset_no_done", done_cnt - d0, 0);

        // Full dump after reset, then back-to-back dumps
        run_dump(1'b1, 1'b0);
        run_dump(1'b1, 1'b0);
        run_dump(1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/debug_dump_sequencer.md
# debug_dump_sequencer

Parametrised word-streaming sequencer that dumps the processor's debug state over the 32-bit-word UART transmit handshake. On one start pulse it sends the PC, then registers 0..N_REGS-1, then data memory words 0..N_MEM_WORDS-1, and optionally a trailing XOR checksum word. It sits between the MIPS debug read ports and `uart_32b`. It replaces the hard-coded dump path of the debug unit with width- and depth-generic logic, and adds abort and checksum capability.

## Interface
- `NB_DATA`, default 32: word width sent per UART transaction.
- `NB_REG_ADDRESS`, default 5: register debug address width.
- `NB_MEM_ADDRESS`, default 7: memory debug address width.
- `N_REGS`, default 32: registers dumped; 1 ≤ N_REGS ≤ 2^NB_REG_ADDRESS.
- `N_MEM_WORDS`, default 128: memory words dumped; 1 ≤ N_MEM_WORDS ≤ 2^NB_MEM_ADDRESS.
- `i_clock` in 1: single clock, all logic on the rising edge.
- `i_reset` in 1: synchronous, active-low reset.
- `i_start` in 1: dump request; sampled only in IDLE.
- `i_abort` in 1: cancel the dump in progress.
- `i_tx_done_32b_word` in 1: one-cycle pulse from the UART marking the end of the current word.
- `i_read_pc` in NB_DATA: current PC value.
- `i_debug_read_reg` in NB_DATA: register data; valid 1 cycle after its address.
- `i_debug_read_mem` in NB_DATA: memory data; valid 1 cycle after its address.
- `o_debug_read_reg_address` out NB_REG_ADDRESS: register index being read.
- `o_debug_read_mem_address` out NB_MEM_ADDRESS: memory index being read.
- `o_enable_uart_send_data` out 1: one-cycle pulse that starts transmission of `o_data_to_send`.
- `o_data_to_send` out NB_DATA: word to transmit.
- `o_busy` out 1: high from the cycle after start is accepted until return to IDLE.
- `o_done` out 1: one-cycle pulse after the last word completes.

## Operation
- State machine states: IDLE, FETCH, LOAD, SEND, WAIT, FINISH.
- A section register selects the source: PC, REG, MEM, and CSUM (CSUM only when the macro is defined).
- IDLE:
  - `i_start`=1 moves to FETCH with section=PC, both indices cleared, checksum cleared.
  - If `i_start` is held high it is not re-armed until IDLE is re-entered.
- FETCH: indices drive the address outputs; the data settles.
- LOAD: `o_data_to_send` is captured from the section source (`i_read_pc`, `i_debug_read_reg`, `i_debug_read_mem`, or the checksum). The checksum is updated by XOR with the captured word, except when the section is CSUM.
- SEND: `o_enable_uart_send_data`=1 for exactly this cycle, then WAIT.
- WAIT: holds until `i_tx_done_32b_word`=1, then advances:
  - PC → REG index 0.
  - REG index N_REGS-1 → MEM index 0.
  - MEM index N_MEM_WORDS-1 → CSUM, or FINISH when the macro is absent.
  - CSUM → FINISH.
  - Otherwise the index increments and the state returns to FETCH.
- FINISH: `o_done`=1 for one cycle, then IDLE.
- Indices never wrap; the last index is N-1.
- Total words sent: 1+N_REGS+N_MEM_WORDS, plus 1 with the checksum.
- `i_tx_done_32b_word` outside WAIT is ignored, including a pulse coinciding with SEND.
- `i_start` outside IDLE is ignored.
- `i_abort`=1 in any non-IDLE state: next state IDLE, no `o_done`, no further send pulse, indices/data/checksum cleared. Abort wins over a simultaneous `i_tx_done_32b_word`. Abort in IDLE has no effect.
- Reset mid-dump behaves as abort.
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Section PC.
  - Checksum 0.

## Timing
- `i_start` sampled high at edge t: FETCH in cycle t+1, LOAD t+2, SEND pulse in cycle t+3.
- WAIT sees done at edge d: next send pulse in cycle d+3.
- `o_data_to_send` is stable from SEND until the accepting `i_tx_done_32b_word` and beyond, until the next LOAD.
- The address outputs hold their value from FETCH through the end of WAIT.
- `o_busy` falls in the cycle after FINISH, in the same cycle IDLE is re-entered.

## Configuration
- `DEBUG_DUMP_CHECKSUM_EN` defined: the CSUM section is compiled in, and the final word equals the XOR of all previously sent words of that dump.
- Not defined: the dump ends after the last memory word, with no checksum register or CSUM logic present.

## Test plan
All scenarios use N_REGS=4 and N_MEM_WORDS=2. The UART model returns done 10 cycles after each send pulse.
- Basic dump, macro off:
  - Stimulus: PC=0x40, reg i=0x100+i, mem j=0xA000+j, one `i_start` pulse.
  - Required: words 0x40, 0x100, 0x101, 0x102, 0x103, 0xA000, 0xA001; exactly 7 send pulses; `o_done` once; first pulse 3 cycles after start.
- Checksum, macro on:
  - Stimulus: same data as the basic dump.
  - Required: 8th word = 0x41, then `o_done`.
- Protocol robustness:
  - Stimulus: spurious `i_tx_done_32b_word` in FETCH, LOAD and SEND cycles; `i_start` pulse mid-dump.
  - Required: sequence and pulse count unchanged.
- Abort:
  - Stimulus: `i_abort` during WAIT of reg 2, coincident with done.
  - Required: IDLE next cycle, `o_busy`=0, no `o_done`, no further pulses. A new start re-sends from PC.
- Reset:
  - Stimulus: `i_reset`=0 for one cycle during mem word 0.
  - Required: all outputs 0 next cycle. A following start produces the full sequence.
- Back-to-back dumps:
  - Stimulus: `i_start` pulsed in the first IDLE cycle after `o_done`.
  - Required: a second identical sequence; with the macro on, the checksum is again 0x41 (checksum cleared between dumps).
